// File: rtl/tensor_burst_mem.sv
// Burst-addressed 3-D tensor memory (entry x row x col): valid/ready write beats in, registered read beats out.
// Optional start-index/length rejection with an err pulse is enabled by defining TENSOR_MEM_BOUNDS_CHECK_EN.
module tensor_burst_mem #(
    parameter int ENTRY_NUM = 1,
    parameter int ROWS      = 1,
    parameter int COLS      = 1,
    parameter int DATA_SIZE = 64,
    parameter int LEN_W     = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_cmd_valid,
    output logic                 o_cmd_ready,
    input  logic                 i_cmd_write,
    input  logic [15:0]          i_cmd_idx_e,
    input  logic [15:0]          i_cmd_idx_r,
    input  logic [15:0]          i_cmd_idx_c,
    input  logic [LEN_W-1:0]     i_cmd_len,
    input  logic                 i_wr_valid,
    output logic                 o_wr_ready,
    input  logic [DATA_SIZE-1:0] i_wr_data,
    output logic                 o_rd_valid,
    input  logic                 i_rd_ready,
    output logic [DATA_SIZE-1:0] o_rd_data,
    output logic                 o_busy,
    output logic                 o_err
);

    localparam int E_W = (ENTRY_NUM > 1) ? $clog2(ENTRY_NUM) : 1;
    localparam int R_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int C_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam logic [E_W-1:0] E_LAST = E_W'(ENTRY_NUM - 1);
    localparam logic [R_W-1:0] R_LAST = R_W'(ROWS - 1);
    localparam logic [C_W-1:0] C_LAST = C_W'(COLS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [E_W-1:0]       r_cur_e;
    logic [R_W-1:0]       r_cur_r;
    logic [C_W-1:0]       r_cur_c;
    logic [E_W-1:0]       w_nxt_e;
    logic [R_W-1:0]       w_nxt_r;
    logic [C_W-1:0]       w_nxt_c;
    logic [LEN_W-1:0]     r_remaining;
    logic                 r_rd_vld_p1;
    logic [DATA_SIZE-1:0] r_rd_data_p1;
    logic                 w_accept;
    logic                 w_reject;
    logic                 w_wr_fire;
    logic                 w_fetch;
    logic                 w_advance;

    logic [DATA_SIZE-1:0] r_mem [ENTRY_NUM][ROWS][COLS];

    assign w_accept = i_cmd_valid && (r_state == ST_IDLE);

`ifdef TENSOR_MEM_BOUNDS_CHECK_EN
    localparam logic [31:0] ENTRY_U = 32'(ENTRY_NUM);
    localparam logic [31:0] ROWS_U  = 32'(ROWS);
    localparam logic [31:0] COLS_U  = 32'(COLS);
    localparam logic [31:0] DEPTH_U = 32'(ENTRY_NUM * ROWS * COLS);

    logic r_err;

    assign w_reject = (32'(i_cmd_idx_e) >= ENTRY_U) || (32'(i_cmd_idx_r) >= ROWS_U) ||
                      (32'(i_cmd_idx_c) >= COLS_U)  || (32'(i_cmd_len) > DEPTH_U);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && w_reject;
        end
    end

    assign o_err = r_err;
`else
    // Upper index bits only matter when range checking is compiled in.
    logic w_unused_idx;
    assign w_unused_idx = ^{i_cmd_idx_e[15:E_W], i_cmd_idx_r[15:R_W], i_cmd_idx_c[15:C_W]};
    assign w_reject     = 1'b0;
    assign o_err        = 1'b0;
`endif

    // Col-fastest walk; the final carry wraps the whole memory back to (0,0,0).
    always_comb begin
        w_nxt_c = r_cur_c + C_W'(1);
        w_nxt_r = r_cur_r;
        w_nxt_e = r_cur_e;
        if (r_cur_c == C_LAST) begin
            w_nxt_c = '0;
            if (r_cur_r == R_LAST) begin
                w_nxt_r = '0;
                w_nxt_e = (r_cur_e == E_LAST) ? '0 : r_cur_e + E_W'(1);
            end else begin
                w_nxt_r = r_cur_r + R_W'(1);
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr_fire   = 1'b0;
        w_fetch     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && !w_reject && (i_cmd_len != '0)) begin
                    w_state_nxt = i_cmd_write ? ST_WRITE : ST_READ;
                end
            end
            ST_WRITE: begin
                w_wr_fire = i_wr_valid;
                if (i_wr_valid && (r_remaining == LEN_W'(1))) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_READ: begin
                w_fetch = (!r_rd_vld_p1 || i_rd_ready) && (r_remaining != '0);
                if (r_rd_vld_p1 && i_rd_ready && (r_remaining == '0)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_advance = w_wr_fire || w_fetch;

    // p0 -> p1: index/counter update and fetch into the one-entry read register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_cur_e      <= '0;
            r_cur_r      <= '0;
            r_cur_c      <= '0;
            r_remaining  <= '0;
            r_rd_vld_p1  <= 1'b0;
            r_rd_data_p1 <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cur_e     <= i_cmd_idx_e[E_W-1:0];
                r_cur_r     <= i_cmd_idx_r[R_W-1:0];
                r_cur_c     <= i_cmd_idx_c[C_W-1:0];
                r_remaining <= i_cmd_len;
            end else if (w_advance) begin
                r_cur_e     <= w_nxt_e;
                r_cur_r     <= w_nxt_r;
                r_cur_c     <= w_nxt_c;
                r_remaining <= r_remaining - LEN_W'(1);
            end
            if (w_fetch) begin
                r_rd_data_p1 <= r_mem[r_cur_e][r_cur_r][r_cur_c];
                r_rd_vld_p1  <= 1'b1;
            end else if (r_rd_vld_p1 && i_rd_ready) begin
                r_rd_vld_p1  <= 1'b0;
            end
        end
    end

    // A beat coinciding with reset is dropped along with the rest of the burst.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && w_wr_fire) begin
            r_mem[r_cur_e][r_cur_r][r_cur_c] <= i_wr_data;
        end
    end

    assign o_cmd_ready = (r_state == ST_IDLE);
    assign o_wr_ready  = (r_state == ST_WRITE);
    assign o_busy      = (r_state != ST_IDLE);
    assign o_rd_valid  = r_rd_vld_p1;
    assign o_rd_data   = r_rd_data_p1;

endmodule

// File: doc/tensor_burst_mem.md
# tensor_burst_mem

Parametrised 3-D tensor memory (entry × row × col) for DNN layer buffers. It replaces single-word random access with command-driven bursts. A burst walks the index space col-fastest with wrap-around. Write beats arrive on a valid/ready stream; read beats leave on a registered valid/ready stream with backpressure. It sits between the layer sequencer (command source) and the compute datapath.

## Interface
- ENTRY_NUM, 1, number of entries (outermost dimension)
- ROWS, 1, rows per entry
- COLS, 1, columns per row (innermost dimension)
- DATA_SIZE, 64, word width in bits (IEEE-754 double in current use)
- LEN_W, 16, burst length field width
- clk  input  1  clock, all logic on rising edge
- rst_n  input  1  synchronous active-low reset
- cmd_valid  input  1  command offered
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_write  input  1  1 = write burst, 0 = read burst
- cmd_idx_e  input  16  start entry index
- cmd_idx_r  input  16  start row index
- cmd_idx_c  input  16  start column index
- cmd_len  input  LEN_W  burst length in words
- wr_valid  input  1  write beat offered
- wr_ready  output  1  write beat accepted
- wr_data  input  DATA_SIZE  write beat data
- rd_valid  output  1  read beat valid
- rd_ready  input  1  consumer accepts read beat
- rd_data  output  DATA_SIZE  read beat data
- busy  output  1  burst in progress (state != IDLE)
- err  output  1  one-cycle pulse on rejected command

## Operation
- Storage: ENTRY_NUM*ROWS*COLS words of DATA_SIZE. Contents are not reset.
- FSM states: IDLE, WRITE, READ. cmd_ready = (state == IDLE).
- Accept: in IDLE on cmd_valid&&cmd_ready, latch start index into cur_e/cur_r/cur_c and cmd_len into remaining.
  - cmd_len == 0: no-op, stay IDLE.
  - Otherwise go to WRITE or READ per cmd_write.
- Index walk after each beat:
  - cur_c+1; at COLS-1, cur_c wraps to 0 and cur_r increments.
  - At ROWS-1, cur_r wraps to 0 and cur_e increments.
  - At ENTRY_NUM-1, cur_e wraps to 0 (whole-memory wrap).
  - Bursts longer than the memory overwrite/re-read from index 0 onward.
- WRITE: wr_ready = 1. Each wr_valid&&wr_ready writes wr_data to mem[cur_e][cur_r][cur_c], advances the index and decrements remaining. At remaining == 1 with a beat accepted, return to IDLE.
- READ:
  - A one-entry output register holds rd_data/rd_valid.
  - Fetch mem[cur] into the register when it is empty or being consumed (!rd_valid || rd_ready) and fetched < length.
  - rd_data and rd_valid are held stable while rd_valid && !rd_ready.
  - Return to IDLE when the last beat is consumed (rd_valid&&rd_ready and no fetches remain).
- wr_ready = 0 outside WRITE. rd_valid never asserts outside READ.
- Reset mid-burst: burst aborted. Already-written words stay in memory. Pending read beat discarded.

## Timing
- Reset values: cmd_ready 1 (IDLE), wr_ready 0, rd_valid 0, rd_data 0, busy 0, err 0.
- Command accepted at edge N: busy high from N+1; wr_ready high from N+1.
- Read latency: first rd_valid at N+2. Continuous rd_ready gives 1 beat/cycle, and an L-word read finishes with its last beat at N+1+L.
- Write throughput: 1 beat/cycle. An L-word burst with continuous wr_valid returns to IDLE at N+1+L; cmd_ready is high that cycle.
- A write is visible to a read command accepted on the cycle after the write burst ends; no forwarding is required.
- err: registered, high for exactly the cycle after a rejected command's accept edge.

## Configuration
- TENSOR_MEM_BOUNDS_CHECK_EN defined:
  - A command is rejected if cmd_idx_e >= ENTRY_NUM, cmd_idx_r >= ROWS, cmd_idx_c >= COLS, or cmd_len > ENTRY_NUM*ROWS*COLS.
  - The rejected command is consumed (handshake completes), state stays IDLE and err pulses once.
- Not defined: no checking, err tied 0. Out-of-range start indices are caller error and behaviour is unspecified.

## Test plan
- ENTRY_NUM=2, ROWS=3, COLS=4. Write burst start (0,0,0), len 24, data 1.0..24.0. Then read burst start (0,0,0), len 24, rd_ready=1 -> rd_data 1.0..24.0 in order, first rd_valid 2 cycles after cmd accept, no gaps.
- Write start (0,2,3) len 2, data A,B -> A at (0,2,3), B at (1,0,0). Write start (1,2,3) len 2, data C,D -> D lands at (0,0,0) (full wrap); read-back confirms.
- Read len 8 with rd_ready toggled 1,0,0,1,... -> rd_data held constant while stalled, all 8 words delivered exactly once, busy drops after the 8th handshake.
- Write len 4 with wr_valid low for 2 cycles mid-burst -> only 4 words written, remaining index continues correctly; cmd_len=0 -> no beats, cmd_ready stays high, busy stays 0.
- Assert rst_n=0 after 3 of 6 read beats -> next cycle rd_valid 0, busy 0, cmd_ready 1; a new command is accepted normally.
- With TENSOR_MEM_BOUNDS_CHECK_EN, cmd_idx_r=3 (ROWS=3) -> cmd accepted, err=1 for one cycle, no beats, memory unchanged. Without the macro, err stays 0.
